// File: rtl/ram_access_master.sv
// Initiator-side controller for a single-port RAM: sequences single or burst
// reads/writes from a valid/ready command port and returns read data as a stream.
module ram_access_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enb,
    output logic                  ram_read_enb,
    output logic [ADDR_WIDTH-1:0] ram_address,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  beats;
    logic [RD_LAT-1:0]     rd_pipe;
    logic                  pipe_pending;

    // Status strobes are decoded from the state register and forced low while reset is held.
    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE) && !reset;
    assign wr_ready  = (state == WRITE) && !reset;
    assign rd_valid  = rd_pipe[RD_LAT-1] && !reset;
    assign rd_data   = rd_valid ? ram_data_out : {DATA_WIDTH{1'b0}};

    // Reads still in flight other than the one returning this cycle; the final stage may be on rd_valid now.
    always_comb begin
        pipe_pending = ram_read_enb;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pipe_pending = pipe_pending | rd_pipe[i];
        end
    end

    // Command sequencer with registered RAM-side outputs and read-latency tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cur_addr      <= {ADDR_WIDTH{1'b0}};
            beats         <= {LEN_WIDTH{1'b0}};
            rd_pipe       <= {RD_LAT{1'b0}};
            done          <= 1'b0;
            ram_write_enb <= 1'b0;
            ram_read_enb  <= 1'b0;
            ram_data_in   <= {DATA_WIDTH{1'b0}};
            ram_address   <= {ADDR_WIDTH{1'b0}};
        end else begin
            rd_pipe       <= RD_LAT'({rd_pipe, ram_read_enb});
            ram_write_enb <= 1'b0;
            ram_read_enb  <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cur_addr <= cmd_addr;
                        beats    <= cmd_len;
                        state    <= cmd_wr ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        ram_write_enb <= 1'b1;
                        ram_address   <= cur_addr;
                        ram_data_in   <= wr_data;
                        cur_addr      <= cur_addr + ADDR_WIDTH'(1);
                        // The last beat still needs its registered write cycle before done.
                        if (beats == {LEN_WIDTH{1'b0}}) begin
                            state <= DRAIN;
                        end else begin
                            beats <= beats - LEN_WIDTH'(1);
                        end
                    end
                end
                READ: begin
                    ram_read_enb <= 1'b1;
                    ram_address  <= cur_addr;
                    cur_addr     <= cur_addr + ADDR_WIDTH'(1);
                    if (beats == {LEN_WIDTH{1'b0}}) begin
                        state <= DRAIN;
                    end else begin
                        beats <= beats - LEN_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (!pipe_pending) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_master.sv
// Scoreboard bench for ram_access_master: a behavioural RAM sits on the RAM pins,
// a reference memory predicts writes/reads, and a negedge monitor checks them.
module tb_ram_access_master;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int LW  = 4;
    localparam int RDL = 1;

    logic          clk = 1'b0;
    logic          reset, cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] wr_data, rd_data, ram_data_in, ram_data_out;
    logic          wr_valid, wr_ready, rd_valid, busy, done;
    logic          ram_write_enb, ram_read_enb;
    logic [AW-1:0] ram_address;

    always #5 clk = ~clk;

    ram_access_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LAT(RDL)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .ram_data_in(ram_data_in), .ram_write_enb(ram_write_enb),
        .ram_read_enb(ram_read_enb), .ram_address(ram_address),
        .ram_data_out(ram_data_out)
    );

    // Behavioural single-port RAM with RDL-cycle read latency.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] dq  [RDL];
    logic          ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (ram_write_enb) begin
            mem[ram_address] <= ram_data_in;
        end
        if (ram_read_enb) dq[0] <= mem[ram_address];
        for (int i = 1; i < RDL; i++) dq[i] <= dq[i-1];
    end
    assign ram_data_out = dq[RDL-1];

    int   cyc = 0;
    logic reset_q;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        reset_q <= reset;
    end

    // Reference model and scoreboard queues.
    logic [DW-1:0] ref_mem [16];
    logic [AW-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    logic [AW-1:0] exp_ra[$];
    logic [DW-1:0] exp_rd[$];
    int            issue_cyc[$];

    int checks = 0, errors = 0;
    int n_rv = 0, n_done = 0, n_we = 0, n_re = 0;
    int last_evt = -100, cur_run = 0, last_run = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: compares everything the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (reset_q === 1'b1 || reset === 1'b1) begin
            if (reset === 1'b1 && reset_q === 1'b1)
                chk({cmd_ready, wr_ready, rd_valid, busy, done, ram_write_enb, ram_read_enb} == 7'd0
                    && rd_data == 8'd0 && ram_data_in == 8'd0 && ram_address == 4'd0,
                    "reset_outputs_zero",
                    int'({cmd_ready, wr_ready, rd_valid, busy, done, ram_write_enb, ram_read_enb}), 0);
        end else begin
            chk(!(ram_write_enb && ram_read_enb), "enables_exclusive",
                int'({ram_write_enb, ram_read_enb}), 0);
            if (ram_write_enb) begin
                n_we++;
                last_evt = cyc;
                chk(exp_wa.size() != 0, "write_expected", int'(ram_address), -1);
                if (exp_wa.size() != 0) begin
                    logic [AW-1:0] a;
                    logic [DW-1:0] d;
                    a = exp_wa.pop_front();
                    d = exp_wd.pop_front();
                    chk(ram_address == a, "write_addr", int'(ram_address), int'(a));
                    chk(ram_data_in == d, "write_data", int'(ram_data_in), int'(d));
                end
            end
            if (ram_read_enb) begin
                n_re++;
                cur_run++;
                issue_cyc.push_back(cyc);
                chk(exp_ra.size() != 0, "read_expected", int'(ram_address), -1);
                if (exp_ra.size() != 0) begin
                    logic [AW-1:0] a;
                    a = exp_ra.pop_front();
                    chk(ram_address == a, "read_addr", int'(ram_address), int'(a));
                end
            end else if (cur_run != 0) begin
                last_run = cur_run;
                cur_run  = 0;
            end
            if (rd_valid) begin
                n_rv++;
                last_evt = cyc;
                chk(exp_rd.size() != 0, "rd_valid_expected", int'(rd_data), -1);
                if (exp_rd.size() != 0) begin
                    logic [DW-1:0] d;
                    d = exp_rd.pop_front();
                    chk(rd_data == d, "rd_data", int'(rd_data), int'(d));
                end
                chk(issue_cyc.size() != 0, "rd_issue_known", 0, 1);
                if (issue_cyc.size() != 0) begin
                    int ic;
                    ic = issue_cyc.pop_front();
                    chk(cyc - ic == RDL, "rd_latency", cyc - ic, RDL);
                end
            end
            if (done) begin
                n_done++;
                chk(cyc == last_evt + 1, "done_timing", cyc - last_evt, 1);
                chk(exp_wa.size() + exp_ra.size() + exp_rd.size() == 0, "done_outstanding",
                    exp_wa.size() + exp_ra.size() + exp_rd.size(), 0);
            end
        end
    end

    // All tasks start and end at a drive point: 1 time unit after a rising edge.
    task automatic do_reset(input int n);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        repeat (n) @(posedge clk);
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_rd.delete();
        issue_cyc.delete();
        last_evt = -100;
        cur_run  = 0;
        #1;
        reset   = 1'b0;
        ram_clr = 1'b0;
        @(negedge clk);
        chk(cmd_ready == 1'b1 && busy == 1'b0, "post_reset_idle", int'({cmd_ready, busy}), 2);
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input bit wr, input int addr, input int len);
        bit acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        cmd_valid = 1'b0;
        chk(acc, "cmd_accept", int'(acc), 1);
    endtask

    // Waits for done; for the first 'stray' cycles drives cmd_valid/wr_valid that must be ignored.
    task automatic wait_done(input int stray, output int busy_low);
        bit seen = 1'b0;
        busy_low = 0;
        for (int t = 0; t < 300; t++) begin
            cmd_valid = (t < stray);
            wr_valid  = (t < stray);
            cmd_wr    = 1'b0;
            @(negedge clk);
            if (!busy) busy_low++;
            seen = done;
            @(posedge clk); #1;
            if (seen) break;
        end
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        chk(seen, "done_seen", int'(seen), 1);
    endtask

    task automatic write_burst(input int addr, input int len, input logic [31:0] pat,
                               input int npat, input int dbase);
        logic [DW-1:0] data [16];
        int sent = 0;
        int bl;
        bit acc;
        for (int i = 0; i <= len; i++) begin
            data[i] = (dbase < 0) ? DW'($urandom_range(0, 255)) : DW'(dbase + i);
            ref_mem[(addr + i) % 16] = data[i];
            exp_wa.push_back(AW'((addr + i) % 16));
            exp_wd.push_back(data[i]);
        end
        send_cmd(1'b1, addr, len);
        for (int t = 0; t < 200 && sent <= len; t++) begin
            wr_valid = (t < npat) ? pat[t] : ($urandom_range(0, 3) != 0);
            wr_data  = data[sent];
            @(negedge clk);
            acc = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        wr_valid = 1'b0;
        chk(sent == len + 1, "write_beats_accepted", sent, len + 1);
        wait_done(0, bl);
    endtask

    task automatic read_burst(input int addr, input int len, input int stray, output int bl);
        for (int i = 0; i <= len; i++) begin
            exp_ra.push_back(AW'((addr + i) % 16));
            exp_rd.push_back(ref_mem[(addr + i) % 16]);
        end
        send_cmd(1'b0, addr, len);
        wait_done(stray, bl);
    endtask

    initial begin
        int bl, we0, re0, rv0, d0, base;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        reset = 1'b1; ram_clr = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0;
        do_reset(2);

        // Single write then read-back.
        we0 = n_we;
        write_burst(3, 0, 32'h0, 0, 8'hA5);
        chk(n_we - we0 == 1, "single_write_count", n_we - we0, 1);
        rv0 = n_rv;
        read_burst(3, 0, 0, bl);
        chk(n_rv - rv0 == 1, "single_read_count", n_rv - rv0, 1);

        // Burst across the address wrap.
        write_burst(14, 3, 32'hF, 4, 1);
        read_burst(14, 3, 0, bl);

        // Gapped write: pattern 1,0,0,1,1.
        we0 = n_we;
        write_burst(6, 2, 32'b11001, 5, 8'h30);
        chk(n_we - we0 == 3, "gapped_write_count", n_we - we0, 3);

        // Full-depth read with stray command/write traffic during the burst.
        rv0 = n_rv; re0 = n_re;
        read_burst(0, 15, 8, bl);
        chk(n_rv - rv0 == 16, "full_read_beats", n_rv - rv0, 16);
        chk(n_re - re0 == 16, "full_read_issues", n_re - re0, 16);
        chk(last_run == 16, "full_read_back_to_back", last_run, 16);
        chk(bl == 0, "busy_throughout", bl, 0);

        // Abort a len=7 read after its second beat.
        for (int i = 0; i < 8; i++) begin
            exp_ra.push_back(AW'((8 + i) % 16));
            exp_rd.push_back(ref_mem[(8 + i) % 16]);
        end
        base = n_rv;
        send_cmd(1'b0, 8, 7);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            if (n_rv - base >= 2) break;
        end
        #1;
        chk(n_rv - base == 2, "abort_point", n_rv - base, 2);
        do_reset(2);
        rv0 = n_rv; re0 = n_re; we0 = n_we; d0 = n_done;
        repeat (10) @(posedge clk);
        #1;
        chk(n_rv == rv0 && n_done == d0 && n_re == re0 && n_we == we0, "quiet_after_abort",
            (n_rv - rv0) + (n_done - d0) + (n_re - re0) + (n_we - we0), 0);
        write_burst(9, 1, 32'h0, 0, -1);
        read_burst(8, 3, 0, bl);

        // Randomised traffic against the reference memory.
        for (int k = 0; k < 24; k++) begin
            int a, l;
            a = $urandom_range(0, 15);
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) write_burst(a, l, 32'h0, 0, -1);
            else read_burst(a, l, 0, bl);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
